// File: rtl/trigger_sequencer.sv
// ----------------------------------------------------------------------------
// trigger_sequencer
//   Multi-source trigger sequencer for the neutron acquisition front end.
//   Rising edges on N_SRC trigger sources are masked and counted. When enough
//   of them land in the same cycle, the block runs a DELAY -> FIRE -> HOLDOFF
//   sequence. The block also provides ARM/VETO gating, source tagging and
//   saturating accept/reject counters.
//
// Ports
//   CLK              system clock, all logic on posedge
//   RST              synchronous reset, active-high
//   SRC_TRIG         raw trigger sources (synchronous to CLK)
//   SRC_MASK         1 = source enabled
//   COINC_MIN        minimum number of simultaneous source edges (0 acts as 1)
//   DELAY_CYC        delay before fire, sampled when DELAY is entered
//   HOLDOFF_CYC      dead time after fire, sampled when HOLDOFF is entered
//   ARM              1 = new triggers may be accepted
//   VETO             1 = reject new triggers / abort a pending delay
//   TRIGGER_OUT      high for PULSE_LEN cycles per accepted trigger
//   TRIGGER_SRC      masked sources that contributed to the last accepted trigger
//   LIVE_ACQUISITION idle, armed and not vetoed
//   ACCEPT_COUNT     triggers fired (saturating)
//   REJECT_COUNT     qualified events that did not fire (saturating)
// ----------------------------------------------------------------------------
module trigger_sequencer #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned EVT_W     = 24
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_SRC-1:0]             SRC_TRIG,
  input  logic [N_SRC-1:0]             SRC_MASK,
  input  logic [$clog2(N_SRC+1)-1:0]   COINC_MIN,
  input  logic [CNT_W-1:0]             DELAY_CYC,
  input  logic [CNT_W-1:0]             HOLDOFF_CYC,
  input  logic                         ARM,
  input  logic                         VETO,
  output logic                         TRIGGER_OUT,
  output logic [N_SRC-1:0]             TRIGGER_SRC,
  output logic                         LIVE_ACQUISITION,
  output logic [EVT_W-1:0]             ACCEPT_COUNT,
  output logic [EVT_W-1:0]             REJECT_COUNT
);

  localparam int unsigned CW = $clog2(N_SRC + 1);
  localparam int unsigned PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DELAY   = 2'd1;
  localparam logic [1:0] ST_FIRE    = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  logic [N_SRC-1:0] src_q, src_q_d;
  logic [N_SRC-1:0] src_edge;
  logic [CW-1:0]    edge_cnt;
  logic [CW-1:0]    coinc_eff;
  logic             qual;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             trig_q, trig_d;
  logic [N_SRC-1:0] tsrc_q, tsrc_d;
  logic [EVT_W-1:0] acc_q, acc_d;
  logic [EVT_W-1:0] rej_q, rej_d;
  logic             acc_inc, rej_inc;

  // Edge detector. Both stages come out of reset as all-ones, so a source
  // that is held high across reset does not produce an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_q   <= '1;
      src_q_d <= '1;
    end else begin
      src_q   <= SRC_TRIG;
      src_q_d <= src_q;
    end
  end

  assign src_edge = src_q & ~src_q_d & SRC_MASK;

  always_comb begin
    edge_cnt = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      edge_cnt = edge_cnt + CW'(src_edge[i]);
    end
  end

  assign coinc_eff = (COINC_MIN == '0) ? CW'(1) : COINC_MIN;
  assign qual      = (edge_cnt >= coinc_eff);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    trig_d  = trig_q;
    tsrc_d  = tsrc_q;
    acc_inc = 1'b0;
    rej_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (qual && ARM) begin
          if (!VETO) begin
            state_d = ST_DELAY;
            cnt_d   = DELAY_CYC;
            tsrc_d  = src_edge;
          end else begin
            rej_inc = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        // Pile-up edges extend the tag but are not counted separately.
        tsrc_d = tsrc_q | src_edge;
        if (VETO) begin
          state_d = ST_IDLE;
          rej_inc = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_FIRE;
          pcnt_d  = PW'(PULSE_LEN - 1);
          trig_d  = 1'b1;
          acc_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIRE: begin
        rej_inc = qual;
        if (pcnt_q == '0) begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLDOFF_CYC;
          trig_d  = 1'b0;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      default: begin
        rej_inc = qual;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    rej_d = rej_q;
    if (acc_inc && (acc_q != '1)) acc_d = acc_q + 1'b1;
    if (rej_inc && (rej_q != '1)) rej_d = rej_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      trig_q  <= 1'b0;
      tsrc_q  <= '0;
      acc_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= trig_d;
      tsrc_q  <= tsrc_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
    end
  end

  assign TRIGGER_OUT      = trig_q;
  assign TRIGGER_SRC      = tsrc_q;
  assign LIVE_ACQUISITION = (state_q == ST_IDLE) & ARM & ~VETO;
  assign ACCEPT_COUNT     = acc_q;
  assign REJECT_COUNT     = rej_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
module tb_trigger_sequencer;
  localparam int N   = 4;
  localparam int CW  = 8;
  localparam int P   = 4;
  localparam int EW  = 4;
  localparam int SAT = (1 << EW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  SRC_TRIG = '0;
  logic [N-1:0]  SRC_MASK = '1;
  logic [2:0]    COINC_MIN = 3'd1;
  logic [CW-1:0] DELAY_CYC = 8'd3;
  logic [CW-1:0] HOLDOFF_CYC = 8'd5;
  logic          ARM = 1'b1;
  logic          VETO = 1'b0;
  logic          TRIGGER_OUT;
  logic [N-1:0]  TRIGGER_SRC;
  logic          LIVE_ACQUISITION;
  logic [EW-1:0] ACCEPT_COUNT;
  logic [EW-1:0] REJECT_COUNT;

  always #5 CLK = ~CLK;

  trigger_sequencer #(.N_SRC(N), .CNT_W(CW), .PULSE_LEN(P), .EVT_W(EW)) dut (
    .CLK(CLK), .RST(RST), .SRC_TRIG(SRC_TRIG), .SRC_MASK(SRC_MASK),
    .COINC_MIN(COINC_MIN), .DELAY_CYC(DELAY_CYC), .HOLDOFF_CYC(HOLDOFF_CYC),
    .ARM(ARM), .VETO(VETO), .TRIGGER_OUT(TRIGGER_OUT), .TRIGGER_SRC(TRIGGER_SRC),
    .LIVE_ACQUISITION(LIVE_ACQUISITION), .ACCEPT_COUNT(ACCEPT_COUNT),
    .REJECT_COUNT(REJECT_COUNT));

  typedef struct {logic trig; logic live; logic [N-1:0] src; int acc; int rej;} exp_t;
  typedef struct {int cyc; logic [N-1:0] src; int acc;} fire_t;
  exp_t  expq[$];
  fire_t fireq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a sequence is described by its acceptance cycle and the
  // latched delay/holdoff lengths; the phase of any cycle follows by arithmetic.
  logic         m_active = 1'b0;
  int           m_a = 0, m_D = 0, m_H = 0;
  logic [N-1:0] m_tag = '0;
  int           m_acc = 0, m_rej = 0;
  logic [N-1:0] m_srcq = '1, m_srcqd = '1;

  // 0 idle, 1 delay, 2 fire, 3 holdoff -- for the cycle following edge x
  function automatic int phase(input int x);
    int rel;
    if (!m_active) return 0;
    rel = x - m_a;
    if (rel <= m_D) return 1;
    if (rel <= m_D + P) return 2;
    return 3;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  task automatic model_step();
    logic [N-1:0] ev;
    int need, ph, rel;
    logic qual;
    if (RST) begin
      m_active = 1'b0; m_tag = '0; m_acc = 0; m_rej = 0;
      m_srcq = '1; m_srcqd = '1;
      return;
    end
    ev   = m_srcq & ~m_srcqd & SRC_MASK;
    need = (COINC_MIN == 0) ? 1 : int'(COINC_MIN);
    qual = ($countones(ev) >= need);
    ph   = phase(cyc - 1);
    rel  = (cyc - 1) - m_a;
    case (ph)
      0: if (qual && ARM) begin
           if (!VETO) begin
             m_active = 1'b1; m_a = cyc; m_D = int'(DELAY_CYC); m_tag = ev;
           end else m_rej = sat_inc(m_rej);
         end
      1: begin
           m_tag = m_tag | ev;
           if (VETO) begin
             m_active = 1'b0; m_rej = sat_inc(m_rej);
           end else if (rel == m_D) begin
             m_acc = sat_inc(m_acc);
             fireq.push_back('{cyc: cyc, src: m_tag, acc: m_acc});
           end
         end
      2: begin
           if (qual) m_rej = sat_inc(m_rej);
           if (rel == m_D + P) m_H = int'(HOLDOFF_CYC);
         end
      default: begin
           if (qual) m_rej = sat_inc(m_rej);
           if (rel == m_D + P + m_H + 1) m_active = 1'b0;
         end
    endcase
    m_srcqd = m_srcq;
    m_srcq  = SRC_TRIG;
  endtask

  task automatic cycle(input logic [N-1:0] src, input logic arm, input logic veto,
                       input logic rst);
    int ph;
    @(posedge CLK);
    cyc++;
    #1;
    model_step();
    SRC_TRIG = src; ARM = arm; VETO = veto; RST = rst;
    ph = phase(cyc);
    expq.push_back('{trig: (ph == 2), live: (ph == 0) && arm && !veto,
                     src: m_tag, acc: m_acc, rej: m_rej});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle outputs against the queued expectation, plus each
  // TRIGGER_OUT rising edge against the queued fire event.
  logic prev_trig = 1'b0;
  initial begin
    exp_t  e;
    fire_t f;
    forever begin
      @(negedge CLK);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if (TRIGGER_OUT !== e.trig || LIVE_ACQUISITION !== e.live ||
            TRIGGER_SRC !== e.src || int'(ACCEPT_COUNT) != e.acc ||
            int'(REJECT_COUNT) != e.rej) begin
          errors++;
          $display("FAIL outputs cyc=%0d: got trig=%b live=%b src=%b acc=%0d rej=%0d, want trig=%b live=%b src=%b acc=%0d rej=%0d",
                   cyc, TRIGGER_OUT, LIVE_ACQUISITION, TRIGGER_SRC, ACCEPT_COUNT,
                   REJECT_COUNT, e.trig, e.live, e.src, e.acc, e.rej);
        end
        if (TRIGGER_OUT === 1'b1 && prev_trig !== 1'b1) begin
          checks++;
          if (fireq.size() == 0) begin
            errors++;
            $display("FAIL fire_event cyc=%0d: got unexpected pulse, want none", cyc);
          end else begin
            f = fireq.pop_front();
            if (f.cyc != cyc || TRIGGER_SRC !== f.src || int'(ACCEPT_COUNT) != f.acc) begin
              errors++;
              $display("FAIL fire_event: got cyc=%0d src=%b acc=%0d, want cyc=%0d src=%b acc=%0d",
                       cyc, TRIGGER_SRC, ACCEPT_COUNT, f.cyc, f.src, f.acc);
            end
          end
        end
      end
      prev_trig = TRIGGER_OUT;
    end
  end

  initial begin
    logic [N-1:0] s, flip;
    // reset, then a source held high across reset must not fire
    cycle(4'b0001, 1'b1, 1'b0, 1'b1);
    cycle(4'b0001, 1'b1, 1'b0, 1'b1);
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    idle(3);
    // single source, delay 3 / holdoff 5
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    idle(22);
    // coincidence of two
    COINC_MIN = 3'd2;
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    idle(6);
    cycle(4'b1001, 1'b1, 1'b0, 1'b0);
    idle(22);
    // veto during delay
    COINC_MIN = 3'd1;
    cycle(4'b0010, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    idle(6);
    // repeated edges through fire, holdoff and the first idle cycle
    for (int i = 0; i < 40; i++) cycle((i % 2 == 0) ? 4'b1000 : 4'b0000, 1'b1, 1'b0, 1'b0);
    idle(20);
    // masked source and disarmed block
    SRC_MASK = 4'b1110;
    for (int i = 0; i < 8; i++) cycle((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle((i % 2 == 0) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1'b0);
    SRC_MASK = 4'b1111;
    // reset while firing
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    idle(5);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    idle(4);
    // counter saturation
    DELAY_CYC = 8'd0; HOLDOFF_CYC = 8'd0;
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0001, 1'b1, 1'b0, 1'b0);
      idle(7);
    end
    // randomized traffic with occasional reconfiguration and reset
    for (int i = 0; i < 4000; i++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 5) == 0);
      s = SRC_TRIG ^ flip;
      cycle(s, $urandom_range(0, 15) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 699) == 0);
      if ($urandom_range(0, 39) == 0) begin
        SRC_MASK    = 4'($urandom_range(0, 15));
        COINC_MIN   = 3'($urandom_range(0, 5));
        DELAY_CYC   = 8'($urandom_range(0, 6));
        HOLDOFF_CYC = 8'($urandom_range(0, 6));
      end
    end
    idle(40);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (fireq.size() != 0) begin
      errors++;
      $display("FAIL fire_drain: got %0d pending fire events, want 0", fireq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
